// File: rtl/moore_seq_gen.sv
// ============================================================================
// Module   : moore_seq_gen
// Purpose  : Moore-style serial pattern generator. On a start request in IDLE
//            it shifts out a PAT_W-bit pattern MSB first, optionally follows it
//            with an odd-parity bit, idles for GAP cycles, then pulses done.
// Ports    : clk     - clock, all state changes on rising edge
//            rst     - asynchronous active-low reset
//            start   - frame request, honoured only in IDLE
//            pat_ld  - load pat_in into the pattern register (IDLE only)
//            pat_in  - new pattern value [PAT_W-1:0]
//            out     - registered serial data
//            busy    - registered, high while a frame is in progress
//            done    - registered, one-cycle end-of-frame pulse
// Config   : define MOORE_SEQ_GEN_PARITY_EN to add the PAR state, which sends
//            an odd-parity bit after the pattern.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_seq_gen #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
  parameter int                GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pat_ld,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
`ifdef MOORE_SEQ_GEN_PARITY_EN
    S_PAR  = 3'd2,
`endif
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Counters load "cycles remaining minus one" and exit on zero.
  localparam logic [3:0] c_bit_last = 4'(PAT_W - 1);
  localparam logic [3:0] c_gap_last = 4'(GAP - 1);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_shift;
  logic [3:0]       r_bitcnt;
  logic [3:0]       r_gapcnt;
  logic             r_out;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [PAT_W-1:0] w_pat_nxt;
  logic [PAT_W-1:0] w_shift_nxt;
  logic [3:0]       w_bitcnt_nxt;
  logic [3:0]       w_gapcnt_nxt;
  logic             w_out_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
`ifdef MOORE_SEQ_GEN_PARITY_EN
  logic             w_par;

  // The pattern register is frozen during a frame, so it still holds the
  // transmitted value when the parity bit is produced.
  assign w_par = ~^r_pat;
`endif

  // --------------------------------------------------------------------------
  // State and output registers. Outputs are computed from the next state so
  // they are true flops and never see a combinational path from inputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pat    <= PATTERN;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pat    <= w_pat_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_out    <= w_out_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_pat_nxt    = r_pat;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;

    case (r_state)
      S_IDLE: begin
        if (pat_ld) begin
          w_pat_nxt = pat_in;
        end
        if (start) begin
          w_state_nxt  = S_SEND;
          // A load on the start edge takes effect for this very frame.
          w_shift_nxt  = pat_ld ? pat_in : r_pat;
          w_bitcnt_nxt = c_bit_last;
        end
      end

      S_SEND: begin
        if (r_bitcnt == 4'd0) begin
`ifdef MOORE_SEQ_GEN_PARITY_EN
          w_state_nxt = S_PAR;
`else
          if (GAP != 0) begin
            w_state_nxt  = S_GAP;
            w_gapcnt_nxt = c_gap_last;
          end else begin
            w_state_nxt = S_DONE;
          end
`endif
        end else begin
          w_shift_nxt  = r_shift << 1;
          w_bitcnt_nxt = r_bitcnt - 4'd1;
        end
      end

`ifdef MOORE_SEQ_GEN_PARITY_EN
      S_PAR: begin
        if (GAP != 0) begin
          w_state_nxt  = S_GAP;
          w_gapcnt_nxt = c_gap_last;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
`endif

      S_GAP: begin
        if (r_gapcnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_gapcnt_nxt = r_gapcnt - 4'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_out_nxt  = 1'b0;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_SEND: begin
        w_busy_nxt = 1'b1;
        w_out_nxt  = w_shift_nxt[PAT_W-1];
      end
`ifdef MOORE_SEQ_GEN_PARITY_EN
      S_PAR: begin
        w_busy_nxt = 1'b1;
        w_out_nxt  = w_par;
      end
`endif
      S_GAP: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_out_nxt = 1'b0;
      end
    endcase
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_gen.sv
// ============================================================================
// Module   : tb_moore_seq_gen
// Purpose  : Scoreboard bench for moore_seq_gen. Stimulus pushes the expected
//            per-cycle {out,busy,done} of each frame; a negedge monitor pops
//            one entry per cycle and requires an idle DUT when empty.
//            A second instance (PAT_W=1, GAP=0) covers the minimum frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moore_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pat_ld;
  logic [3:0] pat_in;
  logic       out;
  logic       busy;
  logic       done;

  logic       start1;
  logic       pat_ld1;
  logic [0:0] pat_in1;
  logic       out1;
  logic       busy1;
  logic       done1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic out;
    logic busy;
    logic done;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  moore_seq_gen #(
    .PAT_W   (4),
    .PATTERN (4'b1101),
    .GAP     (2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pat_ld (pat_ld),
    .pat_in (pat_in),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  moore_seq_gen #(
    .PAT_W   (1),
    .PATTERN (1'b1),
    .GAP     (0)
  ) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .pat_ld (pat_ld1),
    .pat_in (pat_in1),
    .out    (out1),
    .busy   (busy1),
    .done   (done1)
  );

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s out/busy/done got=%b exp=%b at %0t", name, got, exp, $time);
    end
  endtask

  // Expected cycles of one default frame: 4 data bits, optional parity,
  // 2 gap cycles, 1 done cycle.
  task automatic push_frame(input logic [3:0] p, input logic par);
    for (int i = 3; i >= 0; i--) expq.push_back('{p[i], 1'b1, 1'b0});
`ifdef MOORE_SEQ_GEN_PARITY_EN
    expq.push_back('{par, 1'b1, 1'b0});
`else
    if (par === 1'bx) expq.push_back('{1'b0, 1'b1, 1'b0});
`endif
    repeat (2) expq.push_back('{1'b0, 1'b1, 1'b0});
    expq.push_back('{1'b0, 1'b0, 1'b1});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (expq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_idle entries_left=%0d required=0", expq.size());
      expq.delete();
    end
  endtask

  // Monitor: one scoreboard entry per cycle while frames are expected.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sb_cycle", {out, busy, done}, e);
    end else if (rst === 1'b1) begin
      chk("sb_idle", {out, busy, done}, 3'b000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    pat_ld  = 1'b0;
    pat_in  = 4'b0000;
    start1  = 1'b0;
    pat_ld1 = 1'b0;
    pat_in1 = 1'b0;

    // Reset state
    #2;
    chk("reset_outputs", {out, busy, done}, 3'b000);
    chk("reset_outputs_w1", {out1, busy1, done1}, 3'b000);
    #21 rst = 1'b1;

    // Default pattern 1101 (parity 0)
    @(negedge clk); #1;
    start = 1'b1;
    push_frame(4'b1101, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // pat_ld in IDLE, then start: 1001 (parity 1), twice
    @(negedge clk); #1;
    pat_ld = 1'b1;
    pat_in = 4'b1001;
    @(negedge clk); #1;
    pat_ld = 1'b0;
    start  = 1'b1;
    push_frame(4'b1001, 1'b1);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();
    @(negedge clk); #1;
    start = 1'b1;
    push_frame(4'b1001, 1'b1);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // pat_ld with start on the same edge sends pat_in; mid-frame load ignored
    @(negedge clk); #1;
    start  = 1'b1;
    pat_ld = 1'b1;
    pat_in = 4'b1011;
    push_frame(4'b1011, 1'b0);
    @(negedge clk); #1;
    start  = 1'b0;
    pat_in = 4'b0110;
    @(negedge clk); #1;
    pat_ld = 1'b0;
    wait_idle();
    @(negedge clk); #1;
    start = 1'b1;
    push_frame(4'b1011, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset during the third data bit aborts the frame
    @(negedge clk); #1;
    start = 1'b1;
    push_frame(4'b1011, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    expq.delete();
    #1;
    chk("async_reset_drop", {out, busy, done}, 3'b000);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    start = 1'b1;
    push_frame(4'b1101, 1'b0);
    @(negedge clk); #1;
    start = 1'b0;
    wait_idle();

    // start held high for 20 edges: frames at edges 0, P, 2P with one IDLE
    // cycle after each done
    @(negedge clk); #1;
    start = 1'b1;
    push_frame(4'b1101, 1'b0);
    expq.push_back('{1'b0, 1'b0, 1'b0});
    push_frame(4'b1101, 1'b0);
    expq.push_back('{1'b0, 1'b0, 1'b0});
    push_frame(4'b1101, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Minimum configuration: one data bit, no gap
    @(negedge clk); #1;
    start1 = 1'b1;
    @(negedge clk);
    chk("w1_bit", {out1, busy1, done1}, 3'b110);
    #1;
    start1 = 1'b0;
`ifdef MOORE_SEQ_GEN_PARITY_EN
    @(negedge clk);
    chk("w1_parity", {out1, busy1, done1}, 3'b010);
`endif
    @(negedge clk);
    chk("w1_done", {out1, busy1, done1}, 3'b001);
    @(negedge clk);
    chk("w1_idle", {out1, busy1, done1}, 3'b000);

    repeat (4) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
